ex: RTL and testbench

- Execute stage of the 5-stage MIPS32 integer pipeline; sits between id_ex and ex_mem.
- Computes the writeback word plus HI/LO updates for logic, shift, arithmetic, move and multiply operations combinationally.
- Runs DIV/DIVU on an iterative 32-step divider, asserting a stall request until the result is ready.
- Reads HI/LO with forwarding from the MEM and WB stages.

---
 rtl/cpu_defs.sv | 34 +++
 rtl/div.sv | 109 ++++++++++
 rtl/ex.sv | 120 ++++++++++++
 tb/tb_ex.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared operation codes and divider encodings for the execute stage
package cpu_defs;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [7:0] ALUOP_NOP   = 8'h00;
    localparam logic [7:0] ALUOP_OR    = 8'h25;
    localparam logic [7:0] ALUOP_AND   = 8'h24;
    localparam logic [7:0] ALUOP_XOR   = 8'h26;
    localparam logic [7:0] ALUOP_NOR   = 8'h27;
    localparam logic [7:0] ALUOP_SLL   = 8'h7C;
    localparam logic [7:0] ALUOP_SRL   = 8'h02;
    localparam logic [7:0] ALUOP_SRA   = 8'h03;
    localparam logic [7:0] ALUOP_ADDU  = 8'h21;
    localparam logic [7:0] ALUOP_SUBU  = 8'h23;
    localparam logic [7:0] ALUOP_SLT   = 8'h2A;
    localparam logic [7:0] ALUOP_SLTU  = 8'h2B;
    localparam logic [7:0] ALUOP_MFHI  = 8'h10;
    localparam logic [7:0] ALUOP_MTHI  = 8'h11;
    localparam logic [7:0] ALUOP_MFLO  = 8'h12;
    localparam logic [7:0] ALUOP_MTLO  = 8'h13;
    localparam logic [7:0] ALUOP_MULT  = 8'h18;
    localparam logic [7:0] ALUOP_MULTU = 8'h19;
    localparam logic [7:0] ALUOP_DIV   = 8'h1A;
    localparam logic [7:0] ALUOP_DIVU  = 8'h1B;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } div_state_e;

endpackage

// File: rtl/div.sv
// rtl/div.sv - iterative restoring divider, one quotient bit per cycle
module div
    import cpu_defs::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_div_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [63:0] result_q, result_d;

    logic [32:0] partial;
    logic        ge;
    logic [31:0] diff;
    logic [64:0] step;
    logic [31:0] abs_op1, abs_op2, quot, rem;

    // Partial remainder spans 33 bits so divisors >= 2^31 cannot overflow the shift.
    assign partial = dividend_q[64:32];
    assign ge      = partial >= {1'b0, divisor_q};
    assign diff    = partial[31:0] - divisor_q;
    assign step    = ge ? {diff, dividend_q[31:0], 1'b1} : {dividend_q[63:0], 1'b0};
    assign quot    = qneg_q ? -step[31:0] : step[31:0];
    assign rem     = rneg_q ? -step[64:33] : step[64:33];
    assign abs_op1 = (signed_div_i && op1_i[31]) ? -op1_i : op1_i;
    assign abs_op2 = (signed_div_i && op2_i[31]) ? -op2_i : op2_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        result_d   = result_q;
        case (state_q)
            DIV_FREE: begin
                if (start_i) begin
                    if (op2_i == ZERO_WORD) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d    = DIV_ON;
                        cnt_d      = 6'd0;
                        dividend_d = {32'd0, abs_op1, 1'b0};
                        divisor_d  = abs_op2;
                        qneg_d     = signed_div_i && (op1_i[31] ^ op2_i[31]);
                        rneg_d     = signed_div_i && op1_i[31];
                    end
                end
            end
            DIV_BYZERO: begin
                result_d = 64'd0;
                state_d  = DIV_END;
            end
            DIV_ON: begin
                dividend_d = step;
                cnt_d      = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) begin
                    result_d = {rem, quot};
                    state_d  = DIV_END;
                end
            end
            default: state_d = DIV_FREE;
        endcase
        if (annul_i) begin
            state_d = DIV_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= 6'd0;
            dividend_q <= 65'd0;
            divisor_q  <= 32'd0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            result_q   <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            result_q   <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == DIV_END);

endmodule

// File: rtl/ex.sv
// rtl/ex.sv - MIPS32 execute stage: ALU, HI/LO forwarding, multiply and iterative divide
module ex
    import cpu_defs::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        mem_whilo_i,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    input  logic        wb_whilo_i,
    input  logic [31:0] wb_hi_i,
    input  logic [31:0] wb_lo_i,
    input  logic        flush_i,
    output logic [31:0] wdata_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    logic [31:0] fwd_hi, fwd_lo;
    logic [63:0] mul_s, mul_u, div_result;
    logic        is_div, div_ready;

    assign fwd_hi = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
    assign fwd_lo = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);

    assign mul_s = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
    assign mul_u = {32'd0, reg1_i} * {32'd0, reg2_i};

    assign is_div = (aluop_i == ALUOP_DIV) || (aluop_i == ALUOP_DIVU);

    // The divider only honours start while idle, so holding it high during a stall is harmless.
    div #(.DIV_STEPS(DIV_STEPS)) u_div (
        .clk          (clk),
        .rst          (rst),
        .start_i      (is_div && !flush_i),
        .signed_div_i (aluop_i == ALUOP_DIV),
        .op1_i        (reg1_i),
        .op2_i        (reg2_i),
        .annul_i      (flush_i),
        .result_o     (div_result),
        .ready_o      (div_ready)
    );

    always_comb begin
        wdata_o = ZERO_WORD;
        wreg_o  = wreg_i;
        whilo_o = 1'b0;
        hi_o    = ZERO_WORD;
        lo_o    = ZERO_WORD;
        case (aluop_i)
            ALUOP_OR:   wdata_o = reg1_i | reg2_i;
            ALUOP_AND:  wdata_o = reg1_i & reg2_i;
            ALUOP_XOR:  wdata_o = reg1_i ^ reg2_i;
            ALUOP_NOR:  wdata_o = ~(reg1_i | reg2_i);
            ALUOP_SLL:  wdata_o = reg2_i << reg1_i[4:0];
            ALUOP_SRL:  wdata_o = reg2_i >> reg1_i[4:0];
            ALUOP_SRA:  wdata_o = $signed(reg2_i) >>> reg1_i[4:0];
            ALUOP_ADDU: wdata_o = reg1_i + reg2_i;
            ALUOP_SUBU: wdata_o = reg1_i - reg2_i;
            ALUOP_SLT:  wdata_o = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            ALUOP_SLTU: wdata_o = {31'd0, reg1_i < reg2_i};
            ALUOP_MFHI: wdata_o = fwd_hi;
            ALUOP_MFLO: wdata_o = fwd_lo;
            ALUOP_MTHI: begin
                wreg_o  = 1'b0;
                whilo_o = 1'b1;
                hi_o    = reg1_i;
                lo_o    = fwd_lo;
            end
            ALUOP_MTLO: begin
                wreg_o  = 1'b0;
                whilo_o = 1'b1;
                hi_o    = fwd_hi;
                lo_o    = reg1_i;
            end
            ALUOP_MULT: begin
                wreg_o  = 1'b0;
                whilo_o = 1'b1;
                {hi_o, lo_o} = mul_s;
            end
            ALUOP_MULTU: begin
                wreg_o  = 1'b0;
                whilo_o = 1'b1;
                {hi_o, lo_o} = mul_u;
            end
            ALUOP_DIV, ALUOP_DIVU: begin
                wreg_o = 1'b0;
                if (div_ready && !flush_i) begin
                    whilo_o = 1'b1;
                    {hi_o, lo_o} = div_result;
                end
            end
            default: wreg_o = 1'b0;
        endcase
        if (rst) begin
            wdata_o = ZERO_WORD;
            wreg_o  = 1'b0;
            whilo_o = 1'b0;
            hi_o    = ZERO_WORD;
            lo_o    = ZERO_WORD;
        end
    end

    assign wd_o       = rst ? 5'd0 : wd_i;
    assign stallreq_o = !rst && is_div && !div_ready && !flush_i;

endmodule

// File: tb/tb_ex.sv
// tb/tb_ex.sv - directed table and sequence checks for the execute stage
module tb_ex;
    import cpu_defs::*;

    localparam logic [31:0] H0 = 32'h1111_0000;
    localparam logic [31:0] L0 = 32'h2222_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] hi_i, lo_i;
    logic        mem_whilo_i, wb_whilo_i;
    logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
    logic        flush_i;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;

    int n_chk  = 0;
    int n_fail = 0;

    ex dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .hi_i(hi_i), .lo_i(lo_i),
        .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
        .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
        .flush_i(flush_i), .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] r1, r2;
        logic        mw, ww;
        logic [31:0] wdata;
        logic        wreg, whilo;
        logic [31:0] hi, lo;
    } vec_t;

    vec_t vt[20];

    task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stall,
                           input logic [31:0] eh, input logic [31:0] el);
        int stalls = 0;
        @(negedge clk);
        aluop_i = op; reg1_i = a; reg2_i = b;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (!stallreq_o) break;
            stalls++;
            if (stalls == 5) begin
                reg1_i = 32'h5555_5555;
                reg2_i = 32'd0;
            end
            @(negedge clk);
        end
        chk({nm, " stall cycles"}, stalls, exp_stall);
        chk({nm, " whilo"}, {31'd0, whilo_o}, 32'd1);
        chk({nm, " wreg"}, {31'd0, wreg_o}, 32'd0);
        chk({nm, " hi"}, hi_o, eh);
        chk({nm, " lo"}, lo_o, el);
    endtask

    initial begin
        int wh_seen;
        rst = 1'b1; aluop_i = ALUOP_ADDU; reg1_i = 32'd5; reg2_i = 32'd6;
        wd_i = 5'd3; wreg_i = 1'b1; hi_i = H0; lo_i = L0;
        mem_whilo_i = 1'b0; mem_hi_i = 32'h0000_AAAA; mem_lo_i = 32'h0000_A1A1;
        wb_whilo_i = 1'b0;  wb_hi_i = 32'h0000_BBBB;  wb_lo_i = 32'h0000_B1B1;
        flush_i = 1'b0;

        vt[0]  = '{ALUOP_ADDU,  32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 1, 0, 0, 0};
        vt[1]  = '{ALUOP_SLT,   32'hFFFF_FFFF, 32'h1, 0, 0, 32'h1, 1, 0, 0, 0};
        vt[2]  = '{ALUOP_SLTU,  32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0, 0, 0};
        vt[3]  = '{ALUOP_SUBU,  32'h0, 32'h1, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0};
        vt[4]  = '{ALUOP_OR,    32'hF0F0_0000, 32'h0000_F0F0, 0, 0, 32'hF0F0_F0F0, 1, 0, 0, 0};
        vt[5]  = '{ALUOP_AND,   32'hFF00_FF00, 32'h0F0F_0F0F, 0, 0, 32'h0F00_0F00, 1, 0, 0, 0};
        vt[6]  = '{ALUOP_XOR,   32'hFFFF_0000, 32'h0F0F_0F0F, 0, 0, 32'hF0F0_0F0F, 1, 0, 0, 0};
        vt[7]  = '{ALUOP_NOR,   32'h0, 32'h0000_000F, 0, 0, 32'hFFFF_FFF0, 1, 0, 0, 0};
        vt[8]  = '{ALUOP_SLL,   32'd4, 32'h1234_5678, 0, 0, 32'h2345_6780, 1, 0, 0, 0};
        vt[9]  = '{ALUOP_SRL,   32'd8, 32'h8000_0000, 0, 0, 32'h0080_0000, 1, 0, 0, 0};
        vt[10] = '{ALUOP_SRA,   32'd8, 32'h8000_0000, 0, 0, 32'hFF80_0000, 1, 0, 0, 0};
        vt[11] = '{ALUOP_MULT,  32'hFFFF_FFFE, 32'd3, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vt[12] = '{ALUOP_MULTU, 32'hFFFF_FFFE, 32'd3, 0, 0, 32'h0, 0, 1, 32'h0000_0002, 32'hFFFF_FFFA};
        vt[13] = '{ALUOP_MFHI,  32'h0, 32'h0, 1, 1, 32'h0000_AAAA, 1, 0, 0, 0};
        vt[14] = '{ALUOP_MFHI,  32'h0, 32'h0, 0, 1, 32'h0000_BBBB, 1, 0, 0, 0};
        vt[15] = '{ALUOP_MFLO,  32'h0, 32'h0, 0, 0, L0, 1, 0, 0, 0};
        vt[16] = '{ALUOP_MTHI,  32'hDEAD_BEEF, 32'h0, 0, 1, 32'h0, 0, 1, 32'hDEAD_BEEF, 32'h0000_B1B1};
        vt[17] = '{ALUOP_MTLO,  32'hCAFE_F00D, 32'h0, 1, 0, 32'h0, 0, 1, 32'h0000_AAAA, 32'hCAFE_F00D};
        vt[18] = '{ALUOP_NOP,   32'h1, 32'h2, 0, 0, 32'h0, 0, 0, 0, 0};
        vt[19] = '{8'hFF,       32'h1, 32'h2, 0, 0, 32'h0, 0, 0, 0, 0};

        @(negedge clk); #1;
        chk("reset wdata", wdata_o, 32'd0);
        chk("reset wd", {27'd0, wd_o}, 32'd0);
        chk("reset wreg", {31'd0, wreg_o}, 32'd0);
        chk("reset stallreq", {31'd0, stallreq_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            aluop_i = vt[i].op; reg1_i = vt[i].r1; reg2_i = vt[i].r2;
            mem_whilo_i = vt[i].mw; wb_whilo_i = vt[i].ww;
            #1;
            chk($sformatf("vec%0d wdata", i), wdata_o, vt[i].wdata);
            chk($sformatf("vec%0d wreg", i), {31'd0, wreg_o}, {31'd0, vt[i].wreg});
            chk($sformatf("vec%0d whilo", i), {31'd0, whilo_o}, {31'd0, vt[i].whilo});
            chk($sformatf("vec%0d stallreq", i), {31'd0, stallreq_o}, 32'd0);
            chk($sformatf("vec%0d wd", i), {27'd0, wd_o}, 32'd3);
            if (vt[i].whilo) begin
                chk($sformatf("vec%0d hi", i), hi_o, vt[i].hi);
                chk($sformatf("vec%0d lo", i), lo_o, vt[i].lo);
            end
        end
        mem_whilo_i = 1'b0; wb_whilo_i = 1'b0;

        // Signed divide, then confirm whilo drops and a fresh divide starts right after END.
        run_div("div -7/2", ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        @(negedge clk); #1;
        chk("div after end whilo", {31'd0, whilo_o}, 32'd0);
        chk("div after end restart stall", {31'd0, stallreq_o}, 32'd1);
        @(negedge clk); flush_i = 1'b1; aluop_i = ALUOP_NOP;
        @(negedge clk); flush_i = 1'b0;

        run_div("divu 100/7", ALUOP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        @(negedge clk); aluop_i = ALUOP_NOP;
        run_div("divu x/0", ALUOP_DIVU, 32'd1234, 32'd0, 2, 32'd0, 32'd0);
        @(negedge clk); aluop_i = ALUOP_NOP;
        run_div("div min/-1", ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
        @(negedge clk); aluop_i = ALUOP_NOP;

        // Flush in the tenth cycle of a divide.
        @(negedge clk);
        aluop_i = ALUOP_DIV; reg1_i = 32'd100; reg2_i = 32'd3;
        wh_seen = 0;
        for (int c = 1; c < 10; c++) begin
            #1; if (whilo_o) wh_seen++;
            @(negedge clk);
        end
        flush_i = 1'b1; #1;
        chk("flush stallreq", {31'd0, stallreq_o}, 32'd0);
        if (whilo_o) wh_seen++;
        @(negedge clk); flush_i = 1'b0; aluop_i = ALUOP_NOP;
        for (int c = 0; c < 40; c++) begin
            #1; if (whilo_o) wh_seen++;
            @(negedge clk);
        end
        chk("flush whilo seen", wh_seen, 32'd0);
        run_div("div 9/3 after flush", ALUOP_DIV, 32'd9, 32'd3, 33, 32'd0, 32'd3);
        @(negedge clk); aluop_i = ALUOP_NOP;

        // Reset in the middle of a divide.
        @(negedge clk);
        aluop_i = ALUOP_DIVU; reg1_i = 32'd50; reg2_i = 32'd5;
        repeat (5) @(negedge clk);
        rst = 1'b1; #1;
        chk("rst mid stallreq", {31'd0, stallreq_o}, 32'd0);
        chk("rst mid whilo", {31'd0, whilo_o}, 32'd0);
        chk("rst mid hi", hi_o, 32'd0);
        chk("rst mid lo", lo_o, 32'd0);
        chk("rst mid wdata", wdata_o, 32'd0);
        @(negedge clk); rst = 1'b0; aluop_i = ALUOP_NOP;
        run_div("divu 100/7 after rst", ALUOP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        @(negedge clk); aluop_i = ALUOP_NOP;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
